mux_2to1: RTL and testbench



---
 rtl/mux_2to1_pkg.sv | 7 +
 rtl/mux_2to1.sv | 35 +++
 tb/tb_mux_2to1.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mux_2to1_pkg.sv
// Shared constants for the 2:1 selector leaf cell and the map selectors built from it.
package mux_2to1_pkg;

   // Leaf instances are one bit wide; wider selectors replicate or widen the leaf.
   localparam int unsigned MuxLeafWidth = 1;

endpackage

// File: rtl/mux_2to1.sv
// 2:1 selector leaf: zero-latency combinational output plus a flopped copy with
// synchronous active-high reset.
module mux_2to1
   import mux_2to1_pkg::*;
#(
   parameter int unsigned     WIDTH     = MuxLeafWidth,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] out,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out_q
);

   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;

   assign w_out = sel ? in1 : in0;
   assign out   = w_out;

   // Reset only touches the flopped copy; the combinational path never depends on clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_q <= RESET_VAL;
      end else begin
         r_out_q <= w_out;
      end
   end

   assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed vectors, a bit-sliced 7-bit map,
// reset sequences and randomized traffic on a wide instance.
module tb_mux_2to1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Leaf instance under directed test
   logic rst, in0, in1, sel;
   logic out, out_q;

   mux_2to1 #(.WIDTH(1)) u_dut (
      .in0  (in0),
      .in1  (in1),
      .sel  (sel),
      .out  (out),
      .clk  (clk),
      .rst  (rst),
      .out_q(out_q)
   );

   // Wide instance under random test, non-zero reset value
   localparam logic [7:0] WideRst = 8'hA5;
   logic [7:0] w_a, w_b, w_out, w_out_q;
   logic       w_sel, w_rst;

   mux_2to1 #(.WIDTH(8), .RESET_VAL(WideRst)) u_wide (
      .in0  (w_a),
      .in1  (w_b),
      .sel  (w_sel),
      .out  (w_out),
      .clk  (clk),
      .rst  (w_rst),
      .out_q(w_out_q)
   );

   // Bit-sliced 7-bit map selector with an idle clock
   logic       clk_idle = 1'b0;
   logic       rst_idle = 1'b0;
   logic [6:0] m_in0, m_in1, m_out, m_out_q;
   logic       m_sel;

   for (genvar g = 0; g < 7; g++) begin : g_map
      mux_2to1 #(.WIDTH(1)) u_bit (
         .in0  (m_in0[g]),
         .in1  (m_in1[g]),
         .sel  (m_sel),
         .out  (m_out[g]),
         .clk  (clk_idle),
         .rst  (rst_idle),
         .out_q(m_out_q[g])
      );
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference: the selected operand is the element of {in0, in1} indexed by sel
   function automatic logic [7:0] ref_sel(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
      logic [7:0] ops [2];
      ops[0] = a;
      ops[1] = b;
      return ops[s];
   endfunction

   typedef struct {
      string name;
      logic  in0;
      logic  in1;
      logic  sel;
      logic  exp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      logic [7:0] exp_q;
      rst = 1'b1; in0 = 1'b0; in1 = 1'b0; sel = 1'b0;
      w_rst = 1'b1; w_a = '0; w_b = '0; w_sel = 1'b0;
      m_in0 = '0; m_in1 = '0; m_sel = 1'b0;

      // Combinational directed table
      vecs[0] = '{"sel0_in0_0", 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{"sel0_in0_1", 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{"sel1_in1_1", 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{"sel1_in1_0", 1'b1, 1'b0, 1'b1, 1'b0};
      foreach (vecs[i]) begin
         in0 = vecs[i].in0; in1 = vecs[i].in1; sel = vecs[i].sel;
         #1;
         check(vecs[i].name, {7'd0, out}, {7'd0, vecs[i].exp});
      end

      // Bit-sliced map, no clock on the slices
      m_in0 = 7'b1000001; m_in1 = 7'b1100011; m_sel = 1'b0;
      #10 check("map_sel0", {1'b0, m_out}, 8'b0100_0001);
      m_sel = 1'b1;
      #10 check("map_sel1", {1'b0, m_out}, 8'b0110_0011);

      // Reset for two edges
      @(negedge clk); rst = 1'b1; sel = 1'b0; in0 = 1'b0; in1 = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_out_q", {7'd0, out_q}, 8'd0);

      // Release with sel=1, in1=1
      @(negedge clk); rst = 1'b0; sel = 1'b1; in1 = 1'b1;
      #1;
      check("rel_out_now", {7'd0, out}, 8'd1);
      check("rel_out_q_before", {7'd0, out_q}, 8'd0);
      @(posedge clk); #1;
      check("rel_out_q_after", {7'd0, out_q}, 8'd1);

      // Reset mid-operation
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_out_q", {7'd0, out_q}, 8'd0);
      check("mid_rst_out", {7'd0, out}, 8'd1);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rel_out_q", {7'd0, out_q}, 8'd1);

      // Exhaustive 8 combinations: comb now, flop one edge later
      for (int c = 0; c < 8; c++) begin
         logic [2:0] v;
         v = 3'(c);
         @(negedge clk); in0 = v[0]; in1 = v[1]; sel = v[2];
         #1;
         check($sformatf("exh_out_%0d", c), {7'd0, out},
               ref_sel({7'd0, v[0]}, {7'd0, v[1]}, v[2]));
         @(posedge clk); #1;
         check($sformatf("exh_out_q_%0d", c), {7'd0, out_q},
               ref_sel({7'd0, v[0]}, {7'd0, v[1]}, v[2]));
      end

      // Randomized wide traffic with occasional reset
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         w_a   = 8'($urandom);
         w_b   = 8'($urandom);
         w_sel = 1'($urandom);
         w_rst = (i == 0) || ($urandom_range(0, 7) == 0);
         #1;
         check($sformatf("rnd_out_%0d", i), w_out, ref_sel(w_a, w_b, w_sel));
         exp_q = w_rst ? WideRst : ref_sel(w_a, w_b, w_sel);
         @(posedge clk); #1;
         check($sformatf("rnd_out_q_%0d", i), w_out_q, exp_q);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
